// File: rtl/usb_pkg.sv
// usb_pkg: shared constants and entry type for the USB EP6 transmit path.
package usb_pkg;
   localparam int WORD_W = 16;
   localparam logic [1:0] EP6_ADDR = 2'b10;
   localparam int PKT_WORDS_DEF = 256;
   localparam int TIMEOUT_DEF = 1024;
   typedef struct packed {
      logic              last;
      logic [WORD_W-1:0] data;
   } fifo_word_t;
endpackage

// File: rtl/usb_fifo_ram.sv
// usb_fifo_ram: DEPTH x 17 storage, synchronous write, asynchronous read.
module usb_fifo_ram import usb_pkg::*; #(
   parameter int ADDR_W = 4
) (
   input  logic              CLKOUT,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  fifo_word_t        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output fifo_word_t        rdata
);
   fifo_word_t mem [2**ADDR_W];
   always_ff @(posedge CLKOUT)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: FWFT transmit FIFO that tags packet ends on size, flush or idle timeout.
module usb_tx_fifo import usb_pkg::*; #(
   parameter int ADDR_W    = 4,
   parameter int PKT_WORDS = PKT_WORDS_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic              CLKOUT,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W:0]   level
);
   localparam int CW = $clog2(PKT_WORDS) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   logic [ADDR_W:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]     pkt_cnt;
   logic [TW-1:0]     timer;
   logic [WORD_W-1:0] tail_data;
   logic              tail_last;
   logic              push, pop, idle, close, push_last, we;
   logic [ADDR_W-1:0] waddr;
   fifo_word_t        wdata, rdata;
   assign level     = wr_ptr - rd_ptr;
   assign in_ready  = level != (ADDR_W+1)'(2**ADDR_W);
   assign out_valid = level != '0;
   assign out_data  = out_valid ? rdata.data : '0;
   // A flush closing the only stored word must show on the word leaving this cycle
   assign out_last  = out_valid & (rdata.last | (close & level == (ADDR_W+1)'(1)));
   always_comb begin
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      idle      = !push & out_valid & !tail_last;
      close     = idle & (flush | timer == TW'(TIMEOUT-1));
      push_last = flush | pkt_cnt == CW'(PKT_WORDS-1);
      we        = push | close;
      waddr     = push ? wr_ptr[ADDR_W-1:0] : wr_ptr[ADDR_W-1:0] - ADDR_W'(1);
      wdata     = push ? {push_last, in_data} : {1'b1, tail_data};
   end
   // The tail word is mirrored so closing it needs only the single write port
   always_ff @(posedge CLKOUT or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pkt_cnt   <= '0;
         timer     <= '0;
         tail_data <= '0;
         tail_last <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
         if (pop) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
         if (push) begin
            tail_data <= in_data;
            tail_last <= push_last;
         end else if (close) tail_last <= 1'b1;
         if ((push & push_last) | close) pkt_cnt <= '0;
         else if (push) pkt_cnt <= pkt_cnt + CW'(1);
         if (push | close) timer <= '0;
         else if (idle) timer <= timer + TW'(1);
      end
   end
   usb_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
      .CLKOUT(CLKOUT),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_usb_tx_fifo.sv
// tb_usb_tx_fifo: directed stimulus against a queue-based packet model plus literal spot checks.
module tb_usb_tx_fifo;
   localparam int PKT = 256;
   localparam int TMO = 1024;
   logic        CLKOUT = 1'b0;
   logic        rst_n, in_valid, in_ready, flush, out_last, out_valid, out_ready;
   logic [15:0] in_data, out_data;
   logic [4:0]  level;
   logic [16:0] q[$];
   logic [16:0] popped[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   always #5 CLKOUT = ~CLKOUT;
   usb_tx_fifo #(.ADDR_W(4), .PKT_WORDS(PKT), .TIMEOUT(TMO)) dut (
      .CLKOUT   (CLKOUT),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush    (flush),
      .out_data (out_data),
      .out_last (out_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .level    (level)
   );
   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction
   task automatic step();
      @(posedge CLKOUT);
      #1;
   endtask
   function automatic int count_lasts();
      int n = 0;
      foreach (popped[k]) if (popped[k][16]) n++;
      return n;
   endfunction
   // Model: queue of {last,data}; state evolves as the next rising edge will apply it.
   initial begin
      int sz, cnt, idle;
      bit push, pop, open, close, lst;
      logic [16:0] e, t;
      cnt = 0;
      idle = 0;
      forever begin
         @(negedge CLKOUT);
         if (!rst_n) begin
            q.delete();
            cnt = 0;
            idle = 0;
            chk("rst_level", level, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
         end else begin
            sz = q.size();
            push = in_valid && sz < 16;
            pop = out_ready && sz > 0;
            open = sz > 0 && !q[sz-1][16];
            close = !push && open && (flush || idle == TMO-1);
            e = sz > 0 ? q[0] : 17'h0;
            if (close && sz == 1) e[16] = 1'b1;
            chk("level", level, sz);
            chk("in_ready", in_ready, sz != 16);
            chk("out_valid", out_valid, sz != 0);
            chk("out_data", out_data, e[15:0]);
            chk("out_last", out_last, e[16]);
            if (pop) popped.push_back({out_last, out_data});
            if (close) begin
               t = q[sz-1];
               t[16] = 1'b1;
               q[sz-1] = t;
            end
            if (pop) void'(q.pop_front());
            if (push) begin
               lst = flush || cnt == PKT-1;
               q.push_back({lst, in_data});
               cnt = lst ? 0 : cnt + 1;
            end else if (close) cnt = 0;
            idle = (push || close) ? 0 : open ? idle + 1 : idle;
         end
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_n = 0; in_valid = 0; in_data = 0; flush = 0; out_ready = 0;
      repeat (3) step();
      chk("reset_level", level, 0);
      chk("reset_in_ready", in_ready, 1);
      // fill to full, 17th word refused
      rst_n = 1; in_valid = 1;
      for (int i = 1; i <= 17; i++) begin
         in_data = 16'(i);
         step();
      end
      chk("full_level", level, 16);
      chk("full_in_ready", in_ready, 0);
      chk("full_head", out_data, 16'h0001);
      in_valid = 0; flush = 1;
      step();
      flush = 0; out_ready = 1; popped.delete();
      repeat (18) step();
      out_ready = 0;
      chk("fill_pop_count", popped.size(), 16);
      chk("fill_word16", popped[15], 17'h10010);
      chk("fill_word15", popped[14], 17'h0000F);
      // two full packets streamed through
      popped.delete(); out_ready = 1; in_valid = 1;
      for (int i = 0; i < 512; i++) begin
         in_data = 16'h1000 + 16'(i);
         step();
      end
      in_valid = 0;
      repeat (3) step();
      out_ready = 0;
      chk("pkt_pop_count", popped.size(), 512);
      chk("pkt_first", popped[0], 17'h01000);
      chk("pkt_word256", popped[255], 17'h110FF);
      chk("pkt_word512", popped[511], 17'h111FF);
      chk("pkt_last_count", count_lasts(), 2);
      // flush after 5 words, second flush ignored
      popped.delete(); in_valid = 1;
      for (int i = 1; i <= 5; i++) begin
         in_data = 16'h0500 + 16'(i);
         step();
      end
      in_valid = 0;
      step();
      flush = 1; step(); flush = 0; step();
      flush = 1; step(); flush = 0;
      chk("flush_level", level, 5);
      out_ready = 1;
      repeat (7) step();
      out_ready = 0;
      chk("flush_pop_count", popped.size(), 5);
      chk("flush_word5", popped[4], 17'h10505);
      chk("flush_word4", popped[3], 17'h00504);
      // flush while the only word is leaving
      in_valid = 1; in_data = 16'h0701;
      step();
      in_valid = 0; out_ready = 1; flush = 1;
      #3;
      chk("flush_pop_last", out_last, 1);
      chk("flush_pop_data", out_data, 16'h0701);
      step();
      flush = 0; out_ready = 0;
      chk("flush_pop_level", level, 0);
      // idle timeout on a 3-word partial packet
      in_valid = 1;
      for (int i = 1; i <= 3; i++) begin
         in_data = 16'h0800 + 16'(i);
         step();
      end
      in_valid = 0; out_ready = 1;
      step(); step();
      out_ready = 0;
      repeat (TMO-4) step();
      chk("tmo_before_last", out_last, 0);
      chk("tmo_head", out_data, 16'h0803);
      step();
      chk("tmo_at_last", out_last, 1);
      step();
      chk("tmo_after_last", out_last, 1);
      repeat (5) step();
      chk("tmo_held_last", out_last, 1);
      chk("tmo_held_level", level, 1);
      out_ready = 1; step(); out_ready = 0;
      chk("tmo_drained", level, 0);
      // steady push+pop at level 8, then pop on empty
      in_valid = 1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 16'h0900 + 16'(i);
         step();
      end
      out_ready = 1;
      for (int i = 9; i <= 20; i++) begin
         in_data = 16'h0900 + 16'(i);
         step();
      end
      chk("steady_level", level, 8);
      in_valid = 0;
      repeat (10) step();
      chk("empty_level", level, 0);
      chk("empty_out_data", out_data, 0);
      chk("empty_out_valid", out_valid, 0);
      out_ready = 0;
      // reset mid-packet with 10 stored words
      in_valid = 1;
      for (int i = 1; i <= 10; i++) begin
         in_data = 16'h0A00 + 16'(i);
         step();
      end
      in_valid = 0;
      chk("pre_rst_level", level, 10);
      rst_n = 0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_level", level, 0);
      chk("async_rst_ready", in_ready, 1);
      step(); step();
      rst_n = 1; out_ready = 1; in_valid = 1; popped.delete();
      for (int i = 0; i < 256; i++) begin
         in_data = 16'hB000 + 16'(i);
         step();
      end
      in_valid = 0;
      repeat (3) step();
      out_ready = 0;
      chk("post_rst_count", popped.size(), 256);
      chk("post_rst_first", popped[0], 17'h0B000);
      chk("post_rst_word256", popped[255], 17'h1B0FF);
      chk("post_rst_lasts", count_lasts(), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
